pipe_ctrl_decode: RTL and testbench
===================================

// Module: pipe_ctrl_decode
// PURPOSE
//  Main-decode successor for the RISC-V pipeline. Decodes the ID-stage opcode into the
//  control bundle, registers it into ID/EX with stall/flush, adds LUI/AUIPC/JALR decode,
//  illegal-opcode detection, and a RUN/DRAIN/HALTED state machine for HALT.
//  Sits between the IF/ID register and the ID/EX datapath register.
// PARAMETERS
//  DRAIN_CYCLES  4  cycles (advancing, unstalled) after HALT before halted asserts; >=1
//  EN_UPPER      1  1: decode LUI 0110111 / AUIPC 0010111; 0: treat as illegal
//  TRAP_ILLEGAL  0  1: illegal opcode behaves as HALT and sets illegal_sticky; 0: bubble only
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  synchronous, active-high
//  id_valid        in   1  Opcode holds a real instruction this cycle
//  Opcode          in   7  instruction[6:0]
//  stall           in   1  hold ID/EX control register
//  flush           in   1  load bubble into ID/EX; priority over stall
//  ex_valid        out  1  registered: bundle is a real instruction
//  ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, RTypeID, Branch, Jal  out 1 each, registered
//  Jalr, Lui, Auipc  out  1  registered
//  ALUOp           out  2  registered; 00 ld/st/upper, 01 branch, 10 R/I, 11 JALR
//  illegal         out  1  registered; 1-cycle flag with the bubble for an illegal opcode
//  fetch_stop      out  1  combinational from state: 1 in DRAIN and HALTED
//  halted          out  1  registered state bit: 1 in HALTED
//  illegal_sticky  out  1  set by trapped illegal opcode, cleared only by reset
// BEHAVIOUR
//  Clock clk; reset synchronous active-high. Reset: every output 0, state RUN, counter 0.
//  Decode (comb, valid & state==RUN): R 0110011, I 0010011, LW 0000011, SW 0100011,
//   BR 1100011, JAL 1101111, JALR 1100111, HALT 1111111, LUI/AUIPC if EN_UPPER.
//   ALUSrc=LW|SW|I|JALR|LUI|AUIPC; MemtoReg=MemRead=LW; MemWrite=SW;
//   RegWrite=R|LW|I|JAL|JALR|LUI|AUIPC; RTypeID=R; Jal=JAL; Jalr=JALR; Lui/Auipc as named;
//   Branch=BR|JAL|JALR|HALT; ALUOp[0]=BR|JALR; ALUOp[1]=R|I|JALR.
//   Any other opcode: all-zero bundle, illegal=1, ex_valid=0.
//  Register update, latency 1: flush -> bubble (all 0, ex_valid=0, illegal=0);
//   else stall -> hold all; else load decode. id_valid=0 or state!=RUN loads bubble.
//  "Accept" = id_valid & !stall & !flush & state==RUN.
//  FSM: RUN --accept HALT (or illegal with TRAP_ILLEGAL)--> DRAIN, cnt=DRAIN_CYCLES-1.
//   DRAIN: cnt decrements when !stall; cnt==0 & !stall -> HALTED. flush in DRAIN -> RUN
//   (halt was speculative), cnt cleared; flush beats the HALTED transition same cycle.
//   HALTED: sticky until reset; all bundle regs bubble; flush/stall ignored by FSM.
//  illegal_sticky sets same edge the trapped illegal opcode is accepted.
//  cnt width $clog2(DRAIN_CYCLES+1); never wraps (saturates at 0).
//  Reset mid-DRAIN or in HALTED returns to RUN on the next edge, outputs cleared.
// TESTING
//  R-type: Opcode=0110011, id_valid=1 -> next cycle RegWrite=1, ALUOp=10, RTypeID=1, ex_valid=1
//  stall=1 two cycles with new opcode SW -> bundle holds previous LW values; release -> MemWrite=1
//  flush & stall same cycle with LW -> bubble, ex_valid=0, MemRead=0
//  HALT, DRAIN_CYCLES=4, no stall -> fetch_stop next cycle, halted=1 exactly 4 cycles later; 1 stall adds 1
//  HALT then flush 2 cycles later -> state RUN, fetch_stop=0, halted never 1
//  Opcode 0001111, TRAP_ILLEGAL=1 -> illegal=1 one cycle, illegal_sticky=1, enters DRAIN; reset clears all

Source files
------------

// File: rtl/pipe_ctrl_decode_if.sv
// pipe_ctrl_decode_if: ID-stage request and ID/EX control bundle between pipeline and decoder
interface pipe_ctrl_decode_if;
  logic       id_valid;
  logic [6:0] Opcode;
  logic       stall;
  logic       flush;
  logic       ex_valid;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RTypeID;
  logic       Branch;
  logic       Jal;
  logic       Jalr;
  logic       Lui;
  logic       Auipc;
  logic [1:0] ALUOp;
  logic       illegal;
  logic       fetch_stop;
  logic       halted;
  logic       illegal_sticky;
  modport master (
    output id_valid, Opcode, stall, flush,
    input  ex_valid, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, RTypeID, Branch,
           Jal, Jalr, Lui, Auipc, ALUOp, illegal, fetch_stop, halted, illegal_sticky
  );
  modport slave (
    input  id_valid, Opcode, stall, flush,
    output ex_valid, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, RTypeID, Branch,
           Jal, Jalr, Lui, Auipc, ALUOp, illegal, fetch_stop, halted, illegal_sticky
  );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: RISC-V main decode into ID/EX control register with HALT drain state machine
module pipe_ctrl_decode #(
  parameter int DRAIN_CYCLES = 4,
  parameter bit EN_UPPER     = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b0
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_decode_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;
  typedef struct packed {
    logic       ex_valid;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       r_type;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            sticky_q;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_halt, is_lui, is_auipc;
  logic legal, accept, trap_ill, enter_drain;
  assign is_r     = bus.Opcode == 7'b0110011;
  assign is_i     = bus.Opcode == 7'b0010011;
  assign is_lw    = bus.Opcode == 7'b0000011;
  assign is_sw    = bus.Opcode == 7'b0100011;
  assign is_br    = bus.Opcode == 7'b1100011;
  assign is_jal   = bus.Opcode == 7'b1101111;
  assign is_jalr  = bus.Opcode == 7'b1100111;
  assign is_halt  = bus.Opcode == 7'b1111111;
  assign is_lui   = EN_UPPER && bus.Opcode == 7'b0110111;
  assign is_auipc = EN_UPPER && bus.Opcode == 7'b0010111;
  assign legal    = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_halt | is_lui | is_auipc;
  assign accept      = bus.id_valid && !bus.stall && !bus.flush && state_q == RUN;
  assign trap_ill    = accept && TRAP_ILLEGAL && !legal;
  assign enter_drain = (accept && is_halt) || trap_ill;
  always_comb begin
    dec            = '0;
    dec.ex_valid   = legal;
    dec.alu_src    = is_lw | is_sw | is_i | is_jalr | is_lui | is_auipc;
    dec.mem_to_reg = is_lw;
    dec.reg_write  = is_r | is_lw | is_i | is_jal | is_jalr | is_lui | is_auipc;
    dec.mem_read   = is_lw;
    dec.mem_write  = is_sw;
    dec.r_type     = is_r;
    dec.branch     = is_br | is_jal | is_jalr | is_halt;
    dec.jal        = is_jal;
    dec.jalr       = is_jalr;
    dec.lui        = is_lui;
    dec.auipc      = is_auipc;
    dec.alu_op     = {is_r | is_i | is_jalr, is_br | is_jalr};
    dec.illegal    = !legal;
    ctrl_d = (bus.flush || state_q == HALTED) ? '0 :
             bus.stall                        ? ctrl_q :
             (bus.id_valid && state_q == RUN) ? dec : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (trap_ill) sticky_q <= 1'b1;
      case (state_q)
        RUN: if (enter_drain) begin
          state_q <= DRAIN;
          cnt_q   <= CNT_INIT;
        end
        DRAIN: if (bus.flush) begin
          state_q <= RUN;
          cnt_q   <= '0;
        end else if (!bus.stall) begin
          if (cnt_q == '0) state_q <= HALTED;
          else cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= HALTED;
      endcase
    end
  end
  assign bus.ex_valid       = ctrl_q.ex_valid;
  assign bus.ALUSrc         = ctrl_q.alu_src;
  assign bus.MemtoReg       = ctrl_q.mem_to_reg;
  assign bus.RegWrite       = ctrl_q.reg_write;
  assign bus.MemRead        = ctrl_q.mem_read;
  assign bus.MemWrite       = ctrl_q.mem_write;
  assign bus.RTypeID        = ctrl_q.r_type;
  assign bus.Branch         = ctrl_q.branch;
  assign bus.Jal            = ctrl_q.jal;
  assign bus.Jalr           = ctrl_q.jalr;
  assign bus.Lui            = ctrl_q.lui;
  assign bus.Auipc          = ctrl_q.auipc;
  assign bus.ALUOp          = ctrl_q.alu_op;
  assign bus.illegal        = ctrl_q.illegal;
  assign bus.fetch_stop     = state_q != RUN;
  assign bus.halted         = state_q == HALTED;
  assign bus.illegal_sticky = sticky_q;
endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// tb_pipe_ctrl_decode: directed checks of decode, stall/flush, HALT drain and illegal trap
module tb_pipe_ctrl_decode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipe_ctrl_decode_if a();
  pipe_ctrl_decode_if b();
  pipe_ctrl_decode #(.DRAIN_CYCLES(4), .EN_UPPER(1'b1), .TRAP_ILLEGAL(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  pipe_ctrl_decode #(.DRAIN_CYCLES(2), .EN_UPPER(1'b0), .TRAP_ILLEGAL(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  int checks = 0;
  int errors = 0;
  // {ex_valid,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,RTypeID,Branch,Jal,Jalr,Lui,Auipc,ALUOp,illegal}
  logic [14:0] obs_a, obs_b;
  assign obs_a = {a.ex_valid, a.ALUSrc, a.MemtoReg, a.RegWrite, a.MemRead, a.MemWrite, a.RTypeID,
                  a.Branch, a.Jal, a.Jalr, a.Lui, a.Auipc, a.ALUOp, a.illegal};
  assign obs_b = {b.ex_valid, b.ALUSrc, b.MemtoReg, b.RegWrite, b.MemRead, b.MemWrite, b.RTypeID,
                  b.Branch, b.Jal, b.Jalr, b.Lui, b.Auipc, b.ALUOp, b.illegal};
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_HALT = 7'b1111111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BAD = 7'b0001111;
  localparam logic [14:0] B_R     = 15'b1_0_0_1_0_0_1_0_0_0_0_0_10_0;
  localparam logic [14:0] B_I     = 15'b1_1_0_1_0_0_0_0_0_0_0_0_10_0;
  localparam logic [14:0] B_LW    = 15'b1_1_1_1_1_0_0_0_0_0_0_0_00_0;
  localparam logic [14:0] B_SW    = 15'b1_1_0_0_0_1_0_0_0_0_0_0_00_0;
  localparam logic [14:0] B_BR    = 15'b1_0_0_0_0_0_0_1_0_0_0_0_01_0;
  localparam logic [14:0] B_JAL   = 15'b1_0_0_1_0_0_0_1_1_0_0_0_00_0;
  localparam logic [14:0] B_JALR  = 15'b1_1_0_1_0_0_0_1_0_1_0_0_11_0;
  localparam logic [14:0] B_LUI   = 15'b1_1_0_1_0_0_0_0_0_0_1_0_00_0;
  localparam logic [14:0] B_AUIPC = 15'b1_1_0_1_0_0_0_0_0_0_0_1_00_0;
  localparam logic [14:0] B_HALT  = 15'b1_0_0_0_0_0_0_1_0_0_0_0_00_0;
  localparam logic [14:0] B_ILL   = 15'b0_0_0_0_0_0_0_0_0_0_0_0_00_1;
  localparam logic [14:0] B_NONE  = 15'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [6:0] op, input logic st, input logic fl);
    a.id_valid = v; a.Opcode = op; a.stall = st; a.flush = fl;
  endtask

  task automatic drv_b(input logic v, input logic [6:0] op, input logic st, input logic fl);
    b.id_valid = v; b.Opcode = op; b.stall = st; b.flush = fl;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drv_a(0, 7'd0, 0, 0);
    drv_b(0, 7'd0, 0, 0);
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drv_a(1, OP_R, 0, 0);
    drv_b(1, OP_BAD, 0, 0);
    tick;
    tick;
    checks++;
    if (obs_a !== B_NONE) begin errors++; $display("FAIL reset_bundle_a: got %b want %b", obs_a, B_NONE); end
    checks++;
    if ({a.fetch_stop, a.halted, a.illegal_sticky} !== 3'b000) begin
      errors++; $display("FAIL reset_state_a: got %b want 000", {a.fetch_stop, a.halted, a.illegal_sticky});
    end
    checks++;
    if ({obs_b, b.fetch_stop, b.halted, b.illegal_sticky} !== 18'b0) begin
      errors++; $display("FAIL reset_b: got %b want 0", {obs_b, b.fetch_stop, b.halted, b.illegal_sticky});
    end
    reset = 1'b0;
    drv_a(0, 7'd0, 0, 0);
    drv_b(0, 7'd0, 0, 0);
  endtask

  task automatic test_decode;
    logic [6:0]  ops [11] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD, 7'b0000000};
    logic [14:0] exps [11] = '{B_R, B_I, B_LW, B_SW, B_BR, B_JAL, B_JALR, B_LUI, B_AUIPC, B_ILL, B_ILL};
    for (int i = 0; i < 11; i++) begin
      drv_a(1, ops[i], 0, 0);
      tick;
      checks++;
      if (obs_a !== exps[i]) begin
        errors++; $display("FAIL decode_%b: got %b want %b", ops[i], obs_a, exps[i]);
      end
    end
    checks++;
    if ({a.fetch_stop, a.illegal_sticky} !== 2'b00) begin
      errors++; $display("FAIL untrapped_illegal: fetch_stop/sticky got %b want 00", {a.fetch_stop, a.illegal_sticky});
    end
    drv_a(0, OP_R, 0, 0);
    tick;
    checks++;
    if (obs_a !== B_NONE) begin errors++; $display("FAIL invalid_bubble: got %b want %b", obs_a, B_NONE); end
  endtask

  task automatic test_stall;
    drv_a(1, OP_LW, 0, 0);
    tick;
    drv_a(1, OP_SW, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (obs_a !== B_LW) begin errors++; $display("FAIL stall_hold_%0d: got %b want %b", i, obs_a, B_LW); end
    end
    drv_a(1, OP_SW, 0, 0);
    tick;
    checks++;
    if (obs_a !== B_SW || a.MemWrite !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %b want %b", obs_a, B_SW);
    end
  endtask

  task automatic test_flush;
    drv_a(1, OP_LW, 1, 1);
    tick;
    checks++;
    if (obs_a !== B_NONE || a.MemRead !== 1'b0 || a.ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall: got %b want %b", obs_a, B_NONE);
    end
    drv_a(0, 7'd0, 0, 0);
  endtask

  task automatic test_halt;
    drv_a(1, OP_HALT, 0, 0);
    tick;
    checks++;
    if (obs_a !== B_HALT || a.fetch_stop !== 1'b1 || a.halted !== 1'b0) begin
      errors++; $display("FAIL halt_accept: got %b fs=%b h=%b want %b fs=1 h=0", obs_a, a.fetch_stop, a.halted, B_HALT);
    end
    drv_a(1, OP_R, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick;
      checks++;
      if (a.halted !== (k == 4) || obs_a !== B_NONE || a.fetch_stop !== 1'b1) begin
        errors++; $display("FAIL halt_drain_%0d: halted=%b bundle=%b fs=%b want halted=%b bundle=0 fs=1",
                           k, a.halted, obs_a, a.fetch_stop, k == 4);
      end
    end
    drv_a(1, OP_R, 0, 1);
    tick;
    checks++;
    if (a.halted !== 1'b1 || obs_a !== B_NONE) begin
      errors++; $display("FAIL halted_sticky: halted=%b bundle=%b want 1 and 0", a.halted, obs_a);
    end
    do_reset;
    checks++;
    if ({a.halted, a.fetch_stop} !== 2'b00) begin
      errors++; $display("FAIL halted_reset: got %b want 00", {a.halted, a.fetch_stop});
    end
    drv_a(1, OP_HALT, 0, 0);
    tick;
    for (int k = 1; k <= 5; k++) begin
      drv_a(0, 7'd0, k == 2, 0);
      tick;
      checks++;
      if (a.halted !== (k == 5)) begin
        errors++; $display("FAIL halt_stall_%0d: halted=%b want %b", k, a.halted, k == 5);
      end
    end
    do_reset;
  endtask

  task automatic test_halt_flush;
    drv_a(1, OP_HALT, 0, 0);
    tick;
    drv_a(0, 7'd0, 0, 0);
    tick;
    drv_a(0, 7'd0, 0, 1);
    tick;
    checks++;
    if ({a.fetch_stop, a.halted} !== 2'b00) begin
      errors++; $display("FAIL halt_flush: fs/halted got %b want 00", {a.fetch_stop, a.halted});
    end
    drv_a(0, 7'd0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if (a.halted !== 1'b0) begin errors++; $display("FAIL halt_flush_stay_%0d: halted=%b want 0", k, a.halted); end
    end
    drv_a(1, OP_HALT, 0, 0);
    tick;
    drv_a(0, 7'd0, 0, 0);
    for (int k = 0; k < 3; k++) tick;
    drv_a(0, 7'd0, 0, 1);
    tick;
    checks++;
    if ({a.fetch_stop, a.halted} !== 2'b00) begin
      errors++; $display("FAIL flush_beats_halted: fs/halted got %b want 00", {a.fetch_stop, a.halted});
    end
    drv_a(1, OP_JALR, 0, 0);
    tick;
    checks++;
    if (obs_a !== B_JALR) begin errors++; $display("FAIL run_after_flush: got %b want %b", obs_a, B_JALR); end
    drv_a(0, 7'd0, 0, 0);
  endtask

  task automatic test_trap;
    drv_b(1, OP_BAD, 0, 0);
    tick;
    checks++;
    if (obs_b !== B_ILL || b.illegal_sticky !== 1'b1 || b.fetch_stop !== 1'b1) begin
      errors++; $display("FAIL trap_accept: got %b sticky=%b fs=%b want %b 1 1", obs_b, b.illegal_sticky, b.fetch_stop, B_ILL);
    end
    drv_b(0, 7'd0, 0, 0);
    tick;
    checks++;
    if (b.illegal !== 1'b0 || b.halted !== 1'b0 || b.illegal_sticky !== 1'b1) begin
      errors++; $display("FAIL trap_drain: ill=%b halted=%b sticky=%b want 0 0 1", b.illegal, b.halted, b.illegal_sticky);
    end
    tick;
    checks++;
    if (b.halted !== 1'b1 || b.illegal_sticky !== 1'b1) begin
      errors++; $display("FAIL trap_halted: halted=%b sticky=%b want 1 1", b.halted, b.illegal_sticky);
    end
    do_reset;
    checks++;
    if ({obs_b, b.fetch_stop, b.halted, b.illegal_sticky} !== 18'b0) begin
      errors++; $display("FAIL trap_reset: got %b want 0", {obs_b, b.fetch_stop, b.halted, b.illegal_sticky});
    end
    drv_b(1, OP_LUI, 0, 0);
    tick;
    checks++;
    if (obs_b !== B_ILL || b.illegal_sticky !== 1'b1) begin
      errors++; $display("FAIL lui_disabled: got %b sticky=%b want %b 1", obs_b, b.illegal_sticky, B_ILL);
    end
    do_reset;
    drv_b(1, OP_SW, 0, 0);
    tick;
    checks++;
    if (obs_b !== B_SW || b.illegal_sticky !== 1'b0) begin
      errors++; $display("FAIL b_decode_sw: got %b sticky=%b want %b 0", obs_b, b.illegal_sticky, B_SW);
    end
    drv_b(0, 7'd0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_a(0, 7'd0, 0, 0);
    drv_b(0, 7'd0, 0, 0);
    test_reset;
    test_decode;
    test_stall;
    test_flush;
    test_halt;
    test_halt_flush;
    test_trap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
